// File: rtl/br32_pkg.sv
// Shared definitions for the br32 fetch path: the bubble instruction and the
// instruction-cache controller state encoding.
package br32_pkg;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE,
    REFILL
  } icache_state_e;

endpackage

// File: rtl/icache_resp_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache. The master modport is the fetch stage and
// memory arbiter together.
interface icache_resp_if;

  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        istall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output iaddr, flush, mem_ack, mem_rdata,
    input  idata, istall, mem_req, mem_addr
  );

  modport slave (
    input  iaddr, flush, mem_ack, mem_rdata,
    output idata, istall, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_resp_data_ram.sv
// Instruction-cache data array.
// One synchronous write port is used by the refill path. One combinational read port is used by fetch.
module icache_data_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache responder. Hits return data in the same cycle.
// A miss stalls fetch while the whole line is refilled word by word, in order.
module icache_resp
  import br32_pkg::*;
#(
  parameter int          LINES  = 16,
  parameter int          WORDS  = 4,
  parameter logic [31:0] BUBBLE = BUBBLE_INSTR
) (
  input logic          clk,
  input logic          rst,
  icache_resp_if.slave bus
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] req_tag;

  icache_state_e    state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_index;
  logic [OFF_W-1:0] cnt;
  logic             pend_flush;
  logic             mem_req_q;

  logic             hit;
  logic             we;
  logic [31:0]      rdata;
  logic             unused_addr_bits;

  assign offset  = bus.iaddr[2 +: OFF_W];
  assign index   = bus.iaddr[2 + OFF_W +: IDX_W];
  assign req_tag = bus.iaddr[31 -: TAG_W];
  assign unused_addr_bits = ^bus.iaddr[1:0];

  assign hit = (state == IDLE) && valid[index] && (tags[index] == req_tag);
  assign we  = (state == REFILL) && bus.mem_ack && !rst;

  icache_data_ram #(
    .DEPTH(LINES * WORDS),
    .AW   (IDX_W + OFF_W)
  ) u_data_ram (
    .clk  (clk),
    .we   (we),
    .waddr({r_index, cnt}),
    .wdata(bus.mem_rdata),
    .raddr({index, offset}),
    .rdata(rdata)
  );

  assign bus.idata    = hit ? rdata : BUBBLE;
  assign bus.istall   = !hit;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = {r_tag, r_index, cnt, 2'b00};

  // A flush seen during a refill is remembered and applied on the final beat.
  // The line that was just fetched must never become valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      pend_flush <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (!hit) begin
            r_tag     <= req_tag;
            r_index   <= index;
            cnt       <= '0;
            mem_req_q <= 1'b1;
            state     <= REFILL;
          end
        end
        REFILL: begin
          if (bus.flush) pend_flush <= 1'b1;
          if (bus.mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              state      <= IDLE;
              mem_req_q  <= 1'b0;
              pend_flush <= 1'b0;
              if (pend_flush || bus.flush) begin
                valid <= '0;
              end else begin
                valid[r_index] <= 1'b1;
                tags[r_index]  <= r_tag;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_resp.sv
// Directed testbench for icache_resp (LINES=16, WORDS=4).
// The memory model returns {~addr[15:0], addr[15:0]} for each word.
module tb_icache_resp;
  import br32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_resp_if bus ();

  icache_resp #(
    .LINES (16),
    .WORDS (4),
    .BUBBLE(BUBBLE_INSTR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] addr_log [16];
  int          n_log;
  int          req_cycles;
  int          unstable;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign bus.mem_rdata = mem_word(bus.mem_addr);

  // The ack is decided at each falling edge for the next rising edge.
  // When ack_delay is nonzero, each beat waits that many idle request cycles first.
  always @(negedge clk) begin
    if (ack_delay == 0) begin
      bus.mem_ack = 1'b1;
      wait_cnt    = 0;
    end else if (!bus.mem_req) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (wait_cnt == ack_delay) begin
      bus.mem_ack = 1'b1;
      wait_cnt    = 0;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Present addr and count cycles until istall drops.
  // Refill beats are logged. flush is pulsed on stall cycle number flush_at.
  task automatic access(input logic [31:0] addr, input int flush_at, output int stalls);
    logic [31:0] prev_addr;
    logic        prev_wait;
    bus.iaddr  = addr;
    n_log      = 0;
    req_cycles = 0;
    unstable   = 0;
    prev_wait  = 1'b0;
    prev_addr  = '0;
    stalls     = 0;
    #1;
    while (bus.istall && stalls < 200) begin
      if (bus.mem_req) begin
        req_cycles++;
        if (prev_wait && bus.mem_addr !== prev_addr) unstable++;
        if (bus.mem_ack && n_log < 16) begin
          addr_log[n_log] = bus.mem_addr;
          n_log++;
        end
      end
      prev_wait = bus.mem_req && !bus.mem_ack;
      prev_addr = bus.mem_addr;
      stalls++;
      bus.flush = (stalls == flush_at);
      @(negedge clk);
      #1;
    end
    bus.flush = 1'b0;
    n_checks++;
    if (stalls >= 200) begin
      n_fail++;
      $display("[TB] FAIL access_timeout addr=%h: istall still high after %0d cycles, required low", addr, stalls);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.iaddr = 32'h0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b required 0", bus.mem_req); end
    n_checks++; if (bus.istall !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_istall: got %b required 1", bus.istall); end
    n_checks++; if (bus.idata !== BUBBLE_INSTR) begin n_fail++; $display("[TB] FAIL reset_idata: got %h required %h", bus.idata, BUBBLE_INSTR); end
    rst = 1'b0;
  endtask

  task automatic test_miss_fill();
    int st;
    access(32'h100, -1, st);
    n_checks++; if (st !== 5) begin n_fail++; $display("[TB] FAIL miss_stalls: got %0d required 5", st); end
    n_checks++; if (n_log !== 4) begin n_fail++; $display("[TB] FAIL miss_beats: got %0d required 4", n_log); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (addr_log[i] !== 32'h100 + 32'(4 * i)) begin
        n_fail++; $display("[TB] FAIL miss_mem_addr[%0d]: got %h required %h", i, addr_log[i], 32'h100 + 32'(4 * i));
      end
    end
    n_checks++; if (bus.idata !== mem_word(32'h100)) begin n_fail++; $display("[TB] FAIL miss_idata: got %h required %h", bus.idata, mem_word(32'h100)); end
  endtask

  task automatic test_hit();
    int st;
    access(32'h104, -1, st);
    n_checks++; if (st !== 0) begin n_fail++; $display("[TB] FAIL hit_104_stalls: got %0d required 0", st); end
    n_checks++; if (bus.idata !== mem_word(32'h104)) begin n_fail++; $display("[TB] FAIL hit_104_idata: got %h required %h", bus.idata, mem_word(32'h104)); end
    access(32'h10C, -1, st);
    n_checks++; if (st !== 0) begin n_fail++; $display("[TB] FAIL hit_10c_stalls: got %0d required 0", st); end
    n_checks++; if (bus.idata !== mem_word(32'h10C)) begin n_fail++; $display("[TB] FAIL hit_10c_idata: got %h required %h", bus.idata, mem_word(32'h10C)); end
    @(negedge clk); #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_mem_req: got %b required 0", bus.mem_req); end
    n_checks++; if (bus.istall !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_istall_held: got %b required 0", bus.istall); end
  endtask

  task automatic test_conflict();
    int st;
    access(32'h500, -1, st);
    n_checks++; if (st !== 5) begin n_fail++; $display("[TB] FAIL conflict_500_stalls: got %0d required 5", st); end
    n_checks++; if (addr_log[0] !== 32'h500) begin n_fail++; $display("[TB] FAIL conflict_first_addr: got %h required 00000500", addr_log[0]); end
    n_checks++; if (addr_log[3] !== 32'h50C) begin n_fail++; $display("[TB] FAIL conflict_last_addr: got %h required 0000050c", addr_log[3]); end
    n_checks++; if (bus.idata !== mem_word(32'h500)) begin n_fail++; $display("[TB] FAIL conflict_500_idata: got %h required %h", bus.idata, mem_word(32'h500)); end
    access(32'h100, -1, st);
    n_checks++; if (st !== 5) begin n_fail++; $display("[TB] FAIL conflict_100_restalls: got %0d required 5", st); end
    n_checks++; if (bus.idata !== mem_word(32'h100)) begin n_fail++; $display("[TB] FAIL conflict_100_idata: got %h required %h", bus.idata, mem_word(32'h100)); end
  endtask

  task automatic test_delayed_ack();
    int st;
    ack_delay = 3;
    access(32'h308, -1, st);
    ack_delay = 0;
    n_checks++; if (st !== 17) begin n_fail++; $display("[TB] FAIL delay_stalls: got %0d required 17", st); end
    n_checks++; if (req_cycles !== 16) begin n_fail++; $display("[TB] FAIL delay_req_cycles: got %0d required 16", req_cycles); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("[TB] FAIL delay_addr_stable: got %0d changes required 0", unstable); end
    n_checks++; if (n_log !== 4) begin n_fail++; $display("[TB] FAIL delay_beats: got %0d required 4", n_log); end
    n_checks++; if (addr_log[0] !== 32'h300) begin n_fail++; $display("[TB] FAIL delay_first_addr: got %h required 00000300", addr_log[0]); end
    n_checks++; if (bus.idata !== mem_word(32'h308)) begin n_fail++; $display("[TB] FAIL delay_idata: got %h required %h", bus.idata, mem_word(32'h308)); end
  endtask

  task automatic test_flush();
    int st;
    // Flush during the first beat: the refill completes but the line stays invalid, so it misses again.
    access(32'h200, 2, st);
    n_checks++; if (st !== 10) begin n_fail++; $display("[TB] FAIL flush_refill_stalls: got %0d required 10", st); end
    n_checks++; if (n_log !== 8) begin n_fail++; $display("[TB] FAIL flush_refill_beats: got %0d required 8", n_log); end
    n_checks++; if (addr_log[4] !== 32'h200) begin n_fail++; $display("[TB] FAIL flush_refetch_addr: got %h required 00000200", addr_log[4]); end
    n_checks++; if (bus.idata !== mem_word(32'h200)) begin n_fail++; $display("[TB] FAIL flush_refill_idata: got %h required %h", bus.idata, mem_word(32'h200)); end
    bus.flush = 1'b1;
    @(negedge clk); #1;
    bus.flush = 1'b0;
    #1;
    n_checks++; if (bus.istall !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_idle_invalidate: got istall %b required 1", bus.istall); end
    access(32'h200, -1, st);
    n_checks++; if (st !== 5) begin n_fail++; $display("[TB] FAIL flush_idle_restalls: got %0d required 5", st); end
    // Flush together with a miss: the lookup is suppressed and no refill starts.
    bus.iaddr = 32'h600;
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.istall !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_miss_istall: got %b required 1", bus.istall); end
    @(negedge clk); #1;
    bus.flush = 1'b0;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_miss_suppressed: got mem_req %b required 0", bus.mem_req); end
    access(32'h600, -1, st);
    n_checks++; if (st !== 5) begin n_fail++; $display("[TB] FAIL flush_miss_later_stalls: got %0d required 5", st); end
  endtask

  task automatic test_reset_mid_refill();
    int st;
    access(32'h010, -1, st);
    n_checks++; if (st !== 5) begin n_fail++; $display("[TB] FAIL rstmid_prefill_stalls: got %0d required 5", st); end
    bus.iaddr = 32'h220;
    #1;
    repeat (3) begin @(negedge clk); #1; end
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h228) begin
      n_fail++; $display("[TB] FAIL rstmid_beat2: got req %b addr %h required req 1 addr 00000228", bus.mem_req, bus.mem_addr);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_mem_req: got %b required 0", bus.mem_req); end
    n_checks++; if (bus.idata !== BUBBLE_INSTR) begin n_fail++; $display("[TB] FAIL rstmid_idata: got %h required %h", bus.idata, BUBBLE_INSTR); end
    rst = 1'b0;
    access(32'h010, -1, st);
    n_checks++; if (st !== 5) begin n_fail++; $display("[TB] FAIL rstmid_line_lost: got %0d stalls required 5", st); end
    n_checks++; if (addr_log[0] !== 32'h010) begin n_fail++; $display("[TB] FAIL rstmid_refetch_addr: got %h required 00000010", addr_log[0]); end
    n_checks++; if (bus.idata !== mem_word(32'h01C - 32'h00C)) begin n_fail++; $display("[TB] FAIL rstmid_idata_after: got %h required %h", bus.idata, mem_word(32'h010)); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_conflict();
    test_delayed_ack();
    test_flush();
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_resp.md
Name: icache_resp

Overview:
- Instruction-side responder for the fetch stage. Takes the registered fetch address `iaddr` and returns `idata` combinationally in the same cycle.
- Direct-mapped cache of whole lines, with refill from a word-wide memory bus.
- On a miss, asserts `istall`. Integration ORs `istall` into the decode stall so the fetch address is held until the line is resident.
- Sits between the fetch stage and the memory arbiter.

Parameters:
- `LINES`, 16: number of cache lines; power of 2, at least 2.
- `WORDS`, 4: 32-bit words per line; power of 2, at least 2.
- `BUBBLE`, 32'h0000_0013: instruction word driven on `idata` while `istall` is high.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `iaddr`  in  32  fetch address; bits [1:0] ignored.
- `idata`  out  32  instruction word at `iaddr`; combinational.
- `istall`  out  1  high when `idata` is not valid for `iaddr`; combinational.
- `flush`  in  1  one-cycle pulse; invalidate every line.
- `mem_req`  out  1  refill word request.
- `mem_addr`  out  32  word-aligned refill address.
- `mem_ack`  in  1  `mem_rdata` valid; completes the current request.
- `mem_rdata`  in  32  refill data.

Behaviour:
- Address split:
  - offset = `iaddr[2+:log2(WORDS)]`
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage:
  - `valid[LINES]` and `tag[LINES]` are registers.
  - Data array is `LINES*WORDS` words with a combinational read port.
- Hit: `valid[index]` && `tag[index]`==tag && state==IDLE. Then `istall`=0 and `idata`=data[index][offset].
- Any other case: `istall`=1 and `idata`=`BUBBLE`.
- FSM states: IDLE, REFILL.
- IDLE:
  - On a miss (with `flush` low), latch `r_tag`/`r_index` from `iaddr`, clear beat counter `cnt`, and go to REFILL the next cycle.
  - `istall` is high in the miss cycle itself.
- REFILL:
  - `mem_req`=1 and `mem_addr`={`r_tag`, `r_index`, `cnt`, 2'b00}.
  - `mem_req` stays high and `mem_addr` stays stable until `mem_ack`.
  - On `mem_ack`: write `mem_rdata` to data[`r_index`][`cnt`] and increment `cnt`.
  - On the ack with `cnt`==WORDS-1: set `valid[r_index]`=1, `tag[r_index]`=`r_tag`, and return to IDLE.
  - Words are always fetched 0..WORDS-1, with no critical-word-first.
- Latency:
  - Hit: 0 cycles.
  - Miss with `mem_ack` tied high: `istall` high for 1+WORDS cycles, then a hit on the following cycle.
  - `mem_req` is never high in IDLE.
- `mem_ack` while `mem_req` is low is ignored.
- `iaddr` changes during REFILL (exception redirect bypasses stall):
  - The refill completes for the latched line.
  - The new `iaddr` is looked up on return to IDLE and may miss again.
  - No abort.
- `flush`:
  - In IDLE: all valids clear next cycle. A miss lookup in the same cycle is suppressed; `istall` is 1 that cycle and FSM stays IDLE.
  - In REFILL: a pending-flush flag is set; the refill finishes its beats but does not set the valid bit. All valids clear on the final ack.
  - The flag clears on return to IDLE.
- `rst`:
  - Clears all valids, state=IDLE, `cnt`=0, pending-flush=0, `mem_req`=0.
  - Takes effect even mid-refill. The outstanding request is dropped; the memory side must tolerate a dropped request.
  - Data array is not reset.
- Outputs in reset/after reset: `mem_req`=0, `istall`=1 (all lines invalid), `idata`=`BUBBLE`.

Decomposition:
- Shared package `br32_pkg` holds `BUBBLE_INSTR` and the typedef `icache_state_e` {IDLE, REFILL}.
- One natural sub-module: `icache_data_ram` (LINES*WORDS x 32, one synchronous write port, one combinational read port). Tag/valid stays in the top.

Test Plan:
- Reset, then `iaddr`=0x0000_0100 with `mem_ack` tied 1 → `istall` high 5 cycles; `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C; then `idata`=word at 0x100 with `istall`=0.
- After that fill, `iaddr`=0x104, then 0x10C → hit with 0 stall cycles; `mem_req` stays 0.
- Conflict: fill 0x100, then `iaddr`=0x500 (same index, LINES=16 WORDS=4) → refill from 0x500; then 0x100 misses again.
- `mem_ack` delayed 3 cycles per beat → `mem_req`/`mem_addr` held stable while waiting; total stall is 1+4*4 cycles; data correct.
- `flush` pulse mid-refill of 0x200 → refill completes 4 beats; next `iaddr`=0x200 misses again; `flush` in IDLE after a hit → next access to that address misses.
- `rst` asserted at beat 2 of a refill → `mem_req`=0 next cycle; FSM in IDLE; previously valid lines now miss.
